// File: rtl/merge_radio_pkg.sv
// merge_radio_pkg: shared types and constants for the merge_radio transmitter.
//   state_t      : serializer states, IDLE -> START -> TAG -> DATA -> PARITY -> STOP -> GAP
//   TAG_*        : tag bit values that the receive-side splitter uses for steering
//   LINE_*       : line levels on V_Plus (V_Minus is always the complement)
//   FRAME_OVH    : non-payload bits per frame (start, tag, parity, stop)
package merge_radio_pkg;

  typedef enum logic [2:0] {
    IDLE, START, TAG, DATA, PARITY, STOP, GAP
  } state_t;

  localparam logic TAG_RADIO  = 1'b1;
  localparam logic TAG_WIRED  = 1'b0;
  localparam logic LINE_MARK  = 1'b1;
  localparam logic LINE_SPACE = 1'b0;
  localparam int   FRAME_OVH  = 4;

  // Counter width helper: never returns 0 so a 1-count counter still has a bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/merge_radio_fifo.sv
// merge_radio_fifo: single-clock synchronous FIFO, one per input channel.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write request; ignored while full, even with a same-cycle pop
//   pop, pop_data   : read request; pop_data shows the head entry (first-word fall-through)
//   full, empty     : decoded from the registered occupancy count
// DEPTH must be a power of 2 (pointers wrap naturally) and at least 2.
module merge_radio_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/merge_radio.sv
// merge_radio: merges a Radio and a Wired word stream onto one differential line.
//   Clock, Reset               : rising-edge clock, synchronous active-high reset
//   Radio_Data/Valid/Ready     : Radio channel valid/ready input
//   Wired_Data/Valid/Ready     : Wired channel valid/ready input
//   V_Plus, V_Minus            : registered differential line, V_Minus = ~V_Plus
//   Busy                       : high from the START bit through the last idle-gap cycle
// Frame: START(0), TAG(1=Radio), DATA LSB first, even PARITY over TAG+DATA, STOP(1),
// then IDLE_GAP bit-times of mark; every bit lasts BIT_CYCLES clocks. IDLE_GAP >= 1.
// Build option: define MERGE_RADIO_PRIORITY_EN for strict Radio priority instead of
// round-robin arbitration.
module merge_radio
  import merge_radio_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_CYCLES = 4,
  parameter int IDLE_GAP   = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Radio_Data,
  input  logic              Radio_Valid,
  output logic              Radio_Ready,
  input  logic [DATA_W-1:0] Wired_Data,
  input  logic              Wired_Valid,
  output logic              Wired_Ready,
  output logic              V_Plus,
  output logic              V_Minus,
  output logic              Busy
);
  localparam int CW = cnt_w(BIT_CYCLES);
  localparam int BW = cnt_w((DATA_W > IDLE_GAP) ? DATA_W : IDLE_GAP);

  logic              r_full, r_empty, r_pop, w_full, w_empty, w_pop;
  logic [DATA_W-1:0] r_q, w_q, sel_data;

  merge_radio_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_radio_fifo (
    .clk(Clock), .rst(Reset), .push(Radio_Valid), .push_data(Radio_Data),
    .pop(r_pop), .pop_data(r_q), .full(r_full), .empty(r_empty)
  );

  merge_radio_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_wired_fifo (
    .clk(Clock), .rst(Reset), .push(Wired_Valid), .push_data(Wired_Data),
    .pop(w_pop), .pop_data(w_q), .full(w_full), .empty(w_empty)
  );

  assign Radio_Ready = !r_full;
  assign Wired_Ready = !w_full;

  state_t            state, state_nx;
  logic [CW-1:0]     cyc;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              tag, par, line, busy, line_nx;
  logic              bit_end, gap_end, can_load, load, pick_radio;

  assign bit_end = (cyc == CW'(BIT_CYCLES-1));
  assign gap_end = (state == GAP) && bit_end && (bit_cnt == BW'(IDLE_GAP-1));
  // Loading in the last gap cycle lets a waiting word start with no extra idle cycle.
  assign can_load = (state == IDLE) || gap_end;
  assign load     = can_load && (!r_empty || !w_empty);

`ifdef MERGE_RADIO_PRIORITY_EN
  assign pick_radio = !r_empty;
`else
  // last_radio=0 after reset so Radio wins the first tie.
  logic last_radio;
  assign pick_radio = !r_empty && (w_empty || !last_radio);
  always_ff @(posedge Clock) begin
    if (Reset)     last_radio <= 1'b0;
    else if (load) last_radio <= pick_radio;
  end
`endif

  assign r_pop    = load && pick_radio;
  assign w_pop    = load && !pick_radio;
  assign sel_data = pick_radio ? r_q : w_q;

  always_comb begin
    state_nx = state;
    line_nx  = LINE_MARK;
    case (state)
      IDLE:   if (load) state_nx = START;
      START:  begin line_nx = LINE_SPACE; if (bit_end) state_nx = TAG;    end
      TAG:    begin line_nx = tag;        if (bit_end) state_nx = DATA;   end
      DATA:   begin
        line_nx = shreg[0];
        if (bit_end && bit_cnt == BW'(DATA_W-1)) state_nx = PARITY;
      end
      PARITY: begin line_nx = par;        if (bit_end) state_nx = STOP;   end
      STOP:   if (bit_end) state_nx = GAP;
      GAP:    if (gap_end) state_nx = load ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Line and Busy are registered one cycle behind the state, so START appears on the
  // line the edge after the word is loaded.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      cyc     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      tag     <= TAG_WIRED;
      par     <= 1'b0;
      line    <= LINE_MARK;
      busy    <= 1'b0;
    end else begin
      state <= state_nx;
      line  <= line_nx;
      busy  <= (state != IDLE);
      if (load) begin
        shreg   <= sel_data;
        tag     <= pick_radio ? TAG_RADIO : TAG_WIRED;
        par     <= ^{(pick_radio ? TAG_RADIO : TAG_WIRED), sel_data};
        cyc     <= '0;
        bit_cnt <= '0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          cyc     <= '0;
          bit_cnt <= (state_nx != state) ? '0 : bit_cnt + 1'b1;
          if (state == DATA) shreg <= shreg >> 1;
        end else begin
          cyc <= cyc + 1'b1;
        end
      end
    end
  end

  assign V_Plus  = line;
  assign V_Minus = ~line;
  assign Busy    = busy;

endmodule
